// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder and its controller:
// opcodes, responder state encoding and status-register layout.
package spi_flash_pkg;

    localparam logic [7:0] OpWren = 8'h06;
    localparam logic [7:0] OpRdsr = 8'h05;
    localparam logic [7:0] OpRead = 8'h03;
    localparam logic [7:0] OpPp   = 8'h02;

    localparam int unsigned StatusWip = 0;
    localparam int unsigned StatusWel = 1;

    typedef enum logic [2:0] {
        StIdle,
        StOpcode,
        StAddr,
        StStatus,
        StRdData,
        StPpData,
        StIgnore
    } state_e;

    function automatic logic [7:0] status_byte(input logic wel_bit, input logic wip_bit);
        logic [7:0] s;
        s = 8'h00;
        s[StatusWel] = wel_bit;
        s[StatusWip] = wip_bit;
        return s;
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Brings the asynchronous SPI pins into the clk domain and produces
// single-cycle edge pulses for SCK and CS_n from the synchronised copies.
module spi_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic sck,
    input  logic mosi,
    output logic cs_n_sync,
    output logic mosi_sync,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic [1:0] cs_ff_q;
    logic [1:0] sck_ff_q;
    logic [1:0] mosi_ff_q;
    logic       cs_prev_q;
    logic       sck_prev_q;

    // Two-stage synchronisers plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_ff_q    <= 2'b11;
            sck_ff_q   <= 2'b00;
            mosi_ff_q  <= 2'b00;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
        end else begin
            cs_ff_q    <= {cs_ff_q[0], cs_n};
            sck_ff_q   <= {sck_ff_q[0], sck};
            mosi_ff_q  <= {mosi_ff_q[0], mosi};
            cs_prev_q  <= cs_ff_q[1];
            sck_prev_q <= sck_ff_q[1];
        end
    end

    assign cs_n_sync = cs_ff_q[1];
    assign mosi_sync = mosi_ff_q[1];
    assign sck_rise  = sck_ff_q[1] & ~sck_prev_q;
    assign sck_fall  = ~sck_ff_q[1] & sck_prev_q;
    assign cs_fall   = ~cs_ff_q[1] & cs_prev_q;
    assign cs_rise   = cs_ff_q[1] & ~cs_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI flash target model: decodes WREN/RDSR/READ/PP, holds a byte memory,
// a WEL/WIP status register and a program-busy timer.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned PAGE_AW     = 4,
    parameter int unsigned PROG_CYCLES = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_cs_n,
    input  logic spi_sck,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic busy,
    output logic wel
);

    localparam int unsigned TimerW = $clog2(PROG_CYCLES + 1);

    logic cs_n_sync, mosi_sync, sck_rise, sck_fall, cs_fall, cs_rise;

    spi_in_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (spi_cs_n),
        .sck       (spi_sck),
        .mosi      (spi_mosi),
        .cs_n_sync (cs_n_sync),
        .mosi_sync (mosi_sync),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    state_e              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [6:0]          shift_in_q, shift_in_d;  // completed byte = {shift_in_q, mosi_sync}
    logic [7:0]          shift_out_q, shift_out_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [1:0]          addr_byte_q, addr_byte_d;
    logic                is_pp_q, is_pp_d;
    logic                pp_data_q, pp_data_d;    // PP has written at least one byte
    logic                wren_q, wren_d;
    logic                miso_q, miso_d;
    logic                wip_q, wip_d;
    logic                wel_q, wel_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [7:0]          mem [2**MEM_AW];
    logic                mem_we;
    logic [7:0]          rx_byte;
    logic [MEM_AW-1:0]   addr_full;
    logic                byte_done;

    // State register; memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            addr_q      <= '0;
            addr_byte_q <= '0;
            is_pp_q     <= 1'b0;
            pp_data_q   <= 1'b0;
            wren_q      <= 1'b0;
            miso_q      <= 1'b0;
            wip_q       <= 1'b0;
            wel_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            addr_q      <= addr_d;
            addr_byte_q <= addr_byte_d;
            is_pp_q     <= is_pp_d;
            pp_data_q   <= pp_data_d;
            wren_q      <= wren_d;
            miso_q      <= miso_d;
            wip_q       <= wip_d;
            wel_q       <= wel_d;
            timer_q     <= timer_d;
        end
    end

    // Page-program write port.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[addr_q] <= rx_byte;
        end
    end

    // Next-state: bit shifting, opcode decode, status and busy-timer updates.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        addr_d      = addr_q;
        addr_byte_d = addr_byte_q;
        is_pp_d     = is_pp_q;
        pp_data_d   = pp_data_q;
        wren_d      = wren_q;
        miso_d      = miso_q;
        wip_d       = wip_q;
        wel_d       = wel_q;
        timer_d     = timer_q;
        mem_we      = 1'b0;
        rx_byte     = {shift_in_q, mosi_sync};
        addr_full   = {addr_q[MEM_AW-2:0], mosi_sync};
        byte_done   = sck_rise && (bit_cnt_q == 3'd7);

        if (wip_q) begin
            timer_d = timer_q - TimerW'(1);
            if (timer_q == TimerW'(1)) begin
                wip_d = 1'b0;
                wel_d = 1'b0;
            end
        end

        if (state_q != StIdle && cs_rise) begin
            state_d   = StIdle;
            miso_d    = 1'b0;
            bit_cnt_d = '0;
            if (state_q == StPpData && pp_data_q) begin
                wip_d   = 1'b1;
                timer_d = TimerW'(PROG_CYCLES);
            end
            if (state_q == StIgnore && wren_q && !wip_q) begin
                wel_d = 1'b1;
            end
        end else begin
            if (sck_rise) begin
                shift_in_d = rx_byte[6:0];
                bit_cnt_d  = bit_cnt_q + 3'd1;
            end
            if (sck_fall && (state_q == StStatus || state_q == StRdData)) begin
                miso_d      = shift_out_q[7];
                shift_out_d = {shift_out_q[6:0], 1'b0};
            end

            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d   = StOpcode;
                        bit_cnt_d = '0;
                        miso_d    = 1'b0;
                        pp_data_d = 1'b0;
                        wren_d    = 1'b0;
                    end
                end
                StOpcode: begin
                    if (byte_done) begin
                        addr_byte_d = '0;
                        is_pp_d     = (rx_byte == OpPp);
                        case (rx_byte)
                            OpWren: begin
                                state_d = StIgnore;
                                wren_d  = 1'b1;
                            end
                            OpRdsr: begin
                                state_d     = StStatus;
                                shift_out_d = status_byte(wel_q, wip_q);
                            end
                            OpRead:  state_d = StAddr;
                            OpPp:    state_d = (wel_q && !wip_q) ? StAddr : StIgnore;
                            default: state_d = StIgnore;
                        endcase
                    end
                end
                StAddr: begin
                    // Only the low MEM_AW bits of the 24-bit address survive the shift.
                    if (sck_rise) begin
                        addr_d = addr_full;
                        if (bit_cnt_q == 3'd7) begin
                            if (addr_byte_q == 2'd2) begin
                                if (is_pp_q) begin
                                    state_d = StPpData;
                                end else begin
                                    state_d     = StRdData;
                                    shift_out_d = mem[addr_full];
                                    addr_d      = addr_full + MEM_AW'(1);
                                end
                            end else begin
                                addr_byte_d = addr_byte_q + 2'd1;
                            end
                        end
                    end
                end
                StStatus: begin
                    if (byte_done) begin
                        shift_out_d = status_byte(wel_q, wip_q);
                    end
                end
                StRdData: begin
                    if (byte_done) begin
                        shift_out_d = mem[addr_q];
                        addr_d      = addr_q + MEM_AW'(1);
                    end
                end
                StPpData: begin
                    // Page offset wraps; the page base never changes during a PP.
                    if (byte_done) begin
                        mem_we    = 1'b1;
                        pp_data_d = 1'b1;
                        addr_d    = {addr_q[MEM_AW-1:PAGE_AW], addr_q[PAGE_AW-1:0] + PAGE_AW'(1)};
                    end
                end
                StIgnore: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign spi_miso = miso_q & ~cs_n_sync;
    assign busy     = wip_q;
    assign wel      = wel_q;

endmodule
